router_rr: RTL and testbench

ROUTER_RR -- requirements
Module: router_rr

---
 rtl/router_rr.sv | 214 +++++++++++++++++++++
 tb/tb_router_rr.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/router_rr.sv
// Serial packet router: per-input address/pad/payload FSM feeding a payload FIFO,
// per-output round-robin arbiter that streams one granted FIFO per packet.
module router_rr #(
    parameter int NPORTS = 16,
    parameter int PAD    = 5,
    parameter int DEPTH  = 64
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [NPORTS-1:0] din,
    input  logic [NPORTS-1:0] frame_n,
    input  logic [NPORTS-1:0] valid_n,
    output logic [NPORTS-1:0] dout,
    output logic [NPORTS-1:0] frameo_n,
    output logic [NPORTS-1:0] valido_n,
    output logic [NPORTS-1:0] drop
);
    localparam int ADDR_W = $clog2(NPORTS);
    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = $clog2(PAD + ADDR_W + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_PAD   = 3'd2;
    localparam logic [2:0] S_PAY   = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic [NPORTS-1:0][ADDR_W-1:0] dst_all, gsrc_all;
    logic [NPORTS-1:0] req_all, gvld_all, pop_all, close_all, hdata_all, hlast_all;

    for (genvar i = 0; i < NPORTS; i++) begin : g_in
        logic [2:0]        st_q, st_d;
        logic [CW-1:0]     cnt_q, cnt_d;
        logic [ADDR_W-1:0] dst_q, dst_d, addr_sh;
        logic              skip_q, skip_d, lost_q, lost_d, drop_q, drop_d;
        logic [AW:0]       wp_q, rp_q;
        logic [1:0]        mem_q [DEPTH];
        logic [1:0]        head;
        logic              push, empty, full, granted;

        // Address arrives LSB first; shifting in at the MSB leaves bit 0 at the bottom.
        if (ADDR_W == 1) begin : g_a1
            assign addr_sh = din[i];
        end else begin : g_an
            assign addr_sh = {din[i], dst_q[ADDR_W-1:1]};
        end

        assign empty   = (wp_q == rp_q);
        assign full    = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
        assign head    = mem_q[rp_q[AW-1:0]];
        assign granted = gvld_all[dst_q] && (gsrc_all[dst_q] == ADDR_W'(i));

        assign pop_all[i]   = granted && !empty;
        // A discarded last bit is replaced by a close once the FIFO has drained.
        assign close_all[i] = granted && (empty ? lost_q : head[0]);
        assign hdata_all[i] = head[1];
        assign hlast_all[i] = head[0];
        assign req_all[i]   = (st_q == S_PAD) || (st_q == S_PAY) || (st_q == S_DRAIN);
        assign dst_all[i]   = dst_q;
        assign drop[i]      = drop_q;

        always_comb begin
            st_d   = st_q;
            cnt_d  = cnt_q;
            dst_d  = dst_q;
            skip_d = skip_q;
            lost_d = lost_q;
            drop_d = drop_q;
            push   = 1'b0;
            case (st_q)
                S_IDLE: begin
                    if (skip_q) begin
                        if (frame_n[i]) skip_d = 1'b0;
                    end else if (!frame_n[i]) begin
                        dst_d  = addr_sh;
                        lost_d = 1'b0;
                        cnt_d  = (ADDR_W == 1) ? CW'(0) : CW'(1);
                        st_d   = (ADDR_W == 1) ? S_PAD : S_ADDR;
                    end
                end
                S_ADDR: begin
                    dst_d = addr_sh;
                    if (cnt_q == CW'(ADDR_W - 1)) begin
                        st_d  = S_PAD;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_PAD: begin
                    if (cnt_q == CW'(PAD - 1)) st_d = S_PAY;
                    else cnt_d = cnt_q + 1'b1;
                end
                S_PAY: begin
                    if (!valid_n[i]) begin
                        if (full) drop_d = 1'b1;
                        else push = 1'b1;
                        if (frame_n[i]) begin
                            st_d   = S_DRAIN;
                            lost_d = full;
                        end
                    end
                end
                S_DRAIN: begin
                    // A packet starting here is dropped whole; skip tracks its frame.
                    skip_d = !frame_n[i];
                    if (!frame_n[i]) drop_d = 1'b1;
                    if (close_all[i]) st_d = S_IDLE;
                end
                default: st_d = S_IDLE;
            endcase
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                st_q   <= S_IDLE;
                cnt_q  <= '0;
                dst_q  <= '0;
                skip_q <= 1'b0;
                lost_q <= 1'b0;
                drop_q <= 1'b0;
                wp_q   <= '0;
                rp_q   <= '0;
            end else begin
                st_q   <= st_d;
                cnt_q  <= cnt_d;
                dst_q  <= dst_d;
                skip_q <= skip_d;
                lost_q <= lost_d;
                drop_q <= drop_d;
                if (push) wp_q <= wp_q + 1'b1;
                if (pop_all[i]) rp_q <= rp_q + 1'b1;
            end
        end

        always_ff @(posedge clock) begin
            if (push) mem_q[wp_q[AW-1:0]] <= {din[i], frame_n[i]};
        end
    end

    for (genvar o = 0; o < NPORTS; o++) begin : g_out
        logic              gvld_q, gvld_d;
        logic [ADDR_W-1:0] gsrc_q, gsrc_d, ptr_q, ptr_d, start, idx, nsrc;
        logic [NPORTS-1:0] rq;
        logic              closing, found;
        logic              dout_q, dout_d, fo_q, fo_d, vo_q, vo_d;

        always_comb begin
            closing = gvld_q && close_all[gsrc_q];
            // Re-arbitrate on the closing edge so the next packet follows back to back.
            start = closing ? gsrc_q + 1'b1 : ptr_q;
            rq    = '0;
            for (int k = 0; k < NPORTS; k++)
                rq[k] = req_all[k] && (dst_all[k] == ADDR_W'(o)) &&
                        !(closing && (gsrc_q == ADDR_W'(k)));
            found = 1'b0;
            nsrc  = gsrc_q;
            idx   = '0;
            for (int k = 0; k < NPORTS; k++) begin
                idx = start + ADDR_W'(k);
                if (!found && rq[idx]) begin
                    found = 1'b1;
                    nsrc  = idx;
                end
            end
            gvld_d = gvld_q;
            gsrc_d = gsrc_q;
            ptr_d  = closing ? start : ptr_q;
            if (!gvld_q || closing) begin
                gvld_d = found;
                gsrc_d = nsrc;
            end

            dout_d = 1'b0;
            fo_d   = 1'b1;
            vo_d   = 1'b1;
            if (gvld_q) begin
                fo_d = 1'b0;
                if (pop_all[gsrc_q]) begin
                    dout_d = hdata_all[gsrc_q];
                    vo_d   = 1'b0;
                    fo_d   = hlast_all[gsrc_q];
                end else if (closing) begin
                    fo_d = 1'b1;
                end
            end
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                gvld_q <= 1'b0;
                gsrc_q <= '0;
                ptr_q  <= '0;
                dout_q <= 1'b0;
                fo_q   <= 1'b1;
                vo_q   <= 1'b1;
            end else begin
                gvld_q <= gvld_d;
                gsrc_q <= gsrc_d;
                ptr_q  <= ptr_d;
                dout_q <= dout_d;
                fo_q   <= fo_d;
                vo_q   <= vo_d;
            end
        end

        assign gvld_all[o] = gvld_q;
        assign gsrc_all[o] = gsrc_q;
        assign dout[o]     = dout_q;
        assign frameo_n[o] = fo_q;
        assign valido_n[o] = vo_q;
    end

endmodule

// File: tb/tb_router_rr.sv
// Directed bench for router_rr: default 16-port build plus a 4-port PAD=2 build.
module tb_router_rr;
    logic clock = 1'b0;
    logic reset_n = 1'b1;
    logic [15:0] din16 = '0, frm16 = '1, vld16 = '1;
    logic [15:0] dout16, fo16, vo16, drop16;
    logic [3:0]  din4 = '0, frm4 = '1, vld4 = '1;
    logic [3:0]  dout4, fo4, vo4, drop4;

    always #5 clock = ~clock;

    router_rr u16 (
        .clock(clock), .reset_n(reset_n), .din(din16), .frame_n(frm16), .valid_n(vld16),
        .dout(dout16), .frameo_n(fo16), .valido_n(vo16), .drop(drop16));

    router_rr #(.NPORTS(4), .PAD(2), .DEPTH(8)) u4 (
        .clock(clock), .reset_n(reset_n), .din(din4), .frame_n(frm4), .valid_n(vld4),
        .dout(dout4), .frameo_n(fo4), .valido_n(vo4), .drop(drop4));

    typedef struct {
        int src; int dst; int len; logic [31:0] data; int gap_at; int gap_len;
        logic [31:0] exp_data; int exp_len; int exp_gaps;
    } vec_t;

    int n_pass = 0, n_tot = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Output monitor on one selected port of one build.
    bit mq[$], mf[$];
    int mc[$];
    int gaps, closes;
    bit fprev, mon4;
    logic [3:0] mon_o;

    always @(negedge clock) begin
        logic d, f, v;
        if (mon4) begin d = dout4[mon_o[1:0]]; f = fo4[mon_o[1:0]]; v = vo4[mon_o[1:0]]; end
        else begin d = dout16[mon_o]; f = fo16[mon_o]; v = vo16[mon_o]; end
        if (!v) begin mq.push_back(d); mf.push_back(f); mc.push_back(cyc); end
        else if (!f && mq.size() > 0) gaps++;
        if (f && !fprev) closes++;
        fprev = f;
    end

    task automatic mon_clear(input bit is4, input int o);
        mq.delete(); mf.delete(); mc.delete();
        gaps = 0; closes = 0; fprev = 1'b1; mon4 = is4; mon_o = 4'(o);
    endtask

    task automatic chk(input string nm, input longint got, input longint exp);
        n_tot++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    endtask

    task automatic step();
        @(posedge clock); #1;
    endtask

    task automatic put(input bit is4, input int p, input logic d, input logic f, input logic v);
        if (is4) begin din4[p] = d; frm4[p] = f; vld4[p] = v; end
        else begin din16[p] = d; frm16[p] = f; vld16[p] = v; end
    endtask

    task automatic send(input bit is4, input int src, input int dst, input int len,
                        input logic [31:0] data, input int gap_at, input int gap_len,
                        input int stop_at, output int t0);
        int aw, pad;
        aw = is4 ? 2 : 4;
        pad = is4 ? 2 : 5;
        t0 = -1;
        for (int k = 0; k < aw; k++) begin put(is4, src, dst[k], 1'b0, 1'b1); step(); end
        for (int k = 0; k < pad; k++) begin put(is4, src, 1'b0, 1'b0, 1'b1); step(); end
        for (int b = 0; b < len; b++) begin
            if (b == stop_at) break;
            if (b == gap_at)
                for (int g = 0; g < gap_len; g++) begin put(is4, src, 1'b0, 1'b0, 1'b1); step(); end
            put(is4, src, data[b % 32], (b == len - 1), 1'b0);
            if (b == 0) t0 = cyc;
            step();
        end
        put(is4, src, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic check_vec(input string nm, input vec_t v, input int t0);
        logic [31:0] gd, lm;
        gd = '0; lm = '0;
        for (int k = 0; k < mq.size() && k < 32; k++) begin gd[k] = mq[k]; lm[k] = mf[k]; end
        chk({nm, ".len"}, mq.size(), v.exp_len);
        chk({nm, ".data"}, gd, v.exp_data);
        chk({nm, ".lastpos"}, lm, 32'd1 << (v.exp_len - 1));
        chk({nm, ".latency"}, (mc.size() > 0) ? mc[0] - t0 : -1, 2);
        chk({nm, ".gaps"}, gaps, v.exp_gaps);
        chk({nm, ".closes"}, closes, 1);
    endtask

    initial begin
        vec_t tbl[5];
        vec_t v;
        int t0, t1, e4, e6;
        logic [31:0] d4, d6;

        tbl[0] = '{3, 5, 8, 32'hA5, -1, 0, 32'hA5, 8, 0};
        tbl[1] = '{0, 15, 5, 32'h13, -1, 0, 32'h13, 5, 0};
        tbl[2] = '{15, 0, 16, 32'hBEEF, -1, 0, 32'hBEEF, 16, 0};
        tbl[3] = '{7, 7, 1, 32'h1, -1, 0, 32'h1, 1, 0};
        tbl[4] = '{9, 2, 12, 32'h5A3, 4, 3, 32'h5A3, 12, 3};

        #2 reset_n = 1'b0;
        repeat (3) step();
        chk("rst.dout", dout16, 0);
        chk("rst.frameo_n", fo16, 16'hFFFF);
        chk("rst.valido_n", vo16, 16'hFFFF);
        chk("rst.drop", drop16, 0);
        chk("rst4.frameo_n", fo4, 4'hF);
        #2 reset_n = 1'b1;
        step();

        for (int k = 0; k < 5; k++) begin
            mon_clear(1'b0, tbl[k].dst);
            send(1'b0, tbl[k].src, tbl[k].dst, tbl[k].len, tbl[k].data,
                 tbl[k].gap_at, tbl[k].gap_len, -1, t0);
            repeat (6) step();
            check_vec($sformatf("vec%0d", k), tbl[k], t0);
        end

        // Two sources to output 0 in the same cycle: port 1 wins, port 2 follows directly.
        mon_clear(1'b0, 0);
        fork
            send(1'b0, 1, 0, 16, 32'h1234, -1, 0, -1, t0);
            send(1'b0, 2, 0, 16, 32'hFEDC, -1, 0, -1, t1);
        join
        repeat (24) step();
        chk("rr.len", mq.size(), 32);
        begin
            logic [15:0] a, b;
            for (int k = 0; k < 16; k++) begin
                a[k] = (k < mq.size()) ? mq[k] : 1'b0;
                b[k] = (k + 16 < mq.size()) ? mq[k + 16] : 1'b0;
            end
            chk("rr.first", a, 16'h1234);
            chk("rr.second", b, 16'hFEDC);
        end
        if (mq.size() == 32) begin
            chk("rr.b2b", mc[16] - mc[15], 1);
            chk("rr.last1", mf[15], 1);
            chk("rr.last2", mf[31], 1);
        end else chk("rr.size_guard", mq.size(), 32);
        chk("rr.closes", closes, 2);

        // Port 6 overflows its FIFO while output 9 is held by port 4.
        d4 = 32'hC3A50F96;
        d6 = 32'h6B2D94E1;
        mon_clear(1'b0, 9);
        fork
            send(1'b0, 4, 9, 140, d4, -1, 0, -1, t0);
            begin repeat (10) step(); send(1'b0, 6, 9, 100, d6, -1, 0, -1, t1); end
        join
        repeat (90) step();
        chk("ovf.len", mq.size(), 204);
        e4 = 0; e6 = 0;
        for (int b = 0; b < 140; b++) if (b >= mq.size() || mq[b] != d4[b % 32]) e4++;
        for (int b = 0; b < 64; b++) if (b + 140 >= mq.size() || mq[b + 140] != d6[b % 32]) e6++;
        chk("ovf.pkt4_errs", e4, 0);
        chk("ovf.pkt6_errs", e6, 0);
        if (mq.size() == 204) begin
            chk("ovf.last4", mf[139], 1);
            chk("ovf.nolast6", mf[203], 0);
        end else chk("ovf.size_guard", mq.size(), 204);
        chk("ovf.closes", closes, 2);
        chk("ovf.frameo_idle", fo16[9], 1);
        chk("ovf.drop6", drop16[6], 1);
        chk("ovf.drop4", drop16[4], 0);

        // Reset in the middle of a payload, then a clean packet.
        mon_clear(1'b0, 11);
        send(1'b0, 2, 11, 20, 32'h000F0F0F, -1, 0, 10, t0);
        chk("mid.active", mq.size() > 0, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid.dout", dout16, 0);
        chk("mid.frameo_n", fo16, 16'hFFFF);
        chk("mid.valido_n", vo16, 16'hFFFF);
        chk("mid.drop", drop16, 0);
        step(); step();
        #2 reset_n = 1'b1;
        step();
        mon_clear(1'b0, 11);
        v = '{2, 11, 8, 32'h3C, -1, 0, 32'h3C, 8, 0};
        send(1'b0, v.src, v.dst, v.len, v.data, -1, 0, -1, t0);
        repeat (6) step();
        check_vec("post_rst", v, t0);

        // 4-port build: every source/destination pair.
        for (int s = 0; s < 4; s++) begin
            for (int d = 0; d < 4; d++) begin
                logic [31:0] pd;
                pd = 32'((s * 4 + d) ^ 6'h2A);
                v = '{s, d, 6, pd, -1, 0, pd, 6, 0};
                mon_clear(1'b1, d);
                send(1'b1, s, d, 6, pd, -1, 0, -1, t0);
                repeat (6) step();
                check_vec($sformatf("p4_%0d_%0d", s, d), v, t0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
